// File: rtl/diy_uart_rx.sv
// 8N1 UART receiver with a one-entry output holding register and a ready/valid handshake.
// Start bits are re-checked at mid-bit; a low stop bit parks the receiver until the line idles.
module diy_uart_rx #(
    parameter int unsigned CLK_HZ = 24000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_line,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned DIVISOR = CLK_HZ / BAUD;
    localparam int unsigned HALF    = DIVISOR / 2;
    localparam int unsigned CNT_W   = $clog2(DIVISOR);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(DIVISOR - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             rx_meta_q, rx_s;

    // Two-flop synchronizer; resets to idle-high so reset never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= i_line;
            rx_s      <= rx_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StData: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StStop: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
                        // Simultaneous accept frees the holding register for the new byte.
                        if (!valid_q || i_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StBreak: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = (state_q != StIdle) && (state_q != StBreak);

endmodule

// File: tb/tb_diy_uart_rx.sv
// Directed bench for diy_uart_rx at DIVISOR=16, HALF=8: frame table plus corner-case sequences.
module tb_diy_uart_rx;

    localparam int BIT_CYC = 16;

    logic       clk;
    logic       rstn;
    logic       line;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    diy_uart_rx #(
        .CLK_HZ(16),
        .BAUD  (1)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_line     (line),
        .i_ready    (ready),
        .o_data     (data),
        .o_valid    (valid),
        .o_busy     (busy),
        .o_frame_err(frame_err),
        .o_overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_fail = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    logic [7:0] got_q[$];

    // Monitor: every accepted byte and every pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (valid && ready) got_q.push_back(data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        line = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CYC);
        drive_bit(stop, BIT_CYC);
    endtask

    task automatic check_byte(input string name, input logic [7:0] exp);
        logic [7:0] b;
        check({name, "_count"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) begin
            b = got_q.pop_front();
            check({name, "_data"}, {24'd0, b}, {24'd0, exp});
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         gap;
        logic       exp_deliver;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    int n_cyc;
    int ferr0;
    int ovr0;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 20, 1'b1, 0};
        vecs[1] = '{8'h00, 1'b1, 0,  1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 0,  1'b1, 0};
        vecs[3] = '{8'hA5, 1'b1, 20, 1'b1, 0};
        vecs[4] = '{8'h3C, 1'b0, 20, 1'b0, 1};
        vecs[5] = '{8'h81, 1'b1, 20, 1'b1, 0};
        vecs[6] = '{8'h01, 1'b1, 20, 1'b1, 0};
        vecs[7] = '{8'h80, 1'b1, 20, 1'b1, 0};

        rstn  = 1'b0;
        line  = 1'b1;
        ready = 1'b1;
        #2;
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        drive_bit(1'b1, 10);

        // Start-edge to o_valid latency for a 0x55 frame.
        n_cyc = 0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                while (n_cyc < 300 && !valid) begin
                    @(posedge clk);
                    #1;
                    n_cyc++;
                end
            end
        join
        check("lat_55", 32'(n_cyc), 32'd155);
        drive_bit(1'b1, 20);
        check_byte("lat_55", 8'h55);
        check("lat_55_valid_drop", {31'd0, valid}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            ferr0 = ferr_cnt;
            ovr0  = ovr_cnt;
            send_frame(vecs[v].d, vecs[v].stop);
            drive_bit(1'b1, vecs[v].gap);
            if (vecs[v].exp_deliver) check_byte($sformatf("vec%0d", v), vecs[v].d);
            else check($sformatf("vec%0d_nobyte", v), 32'(got_q.size()), 32'd0);
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - ferr0), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_ovr", v), 32'(ovr_cnt - ovr0), 32'd0);
            if (vecs[v].gap > 0) check($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
        end

        // Five-cycle low glitch on an idle line.
        ferr0 = ferr_cnt;
        drive_bit(1'b0, 5);
        check("glitch_busy_in_start", {31'd0, busy}, 32'd1);
        drive_bit(1'b1, 20);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_valid", {31'd0, valid}, 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - ferr0), 32'd0);
        check("glitch_nobyte", 32'(got_q.size()), 32'd0);

        // Frame error followed by a long low line: BREAK must not restart.
        ferr0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 40);
        check("brk_busy_low", {31'd0, busy}, 32'd0);
        check("brk_ferr", 32'(ferr_cnt - ferr0), 32'd1);
        check("brk_nobyte", 32'(got_q.size()), 32'd0);
        drive_bit(1'b1, 20);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1, 20);
        check_byte("brk_next", 8'h81);
        check("brk_ferr_after", 32'(ferr_cnt - ferr0), 32'd1);

        // Overrun: consumer not ready for two frames.
        ready = 1'b0;
        ovr0  = ovr_cnt;
        send_frame(8'h11, 1'b1);
        drive_bit(1'b1, 20);
        check("ovr_first_valid", {31'd0, valid}, 32'd1);
        send_frame(8'h22, 1'b1);
        drive_bit(1'b1, 20);
        check("ovr_data_held", {24'd0, data}, 32'h11);
        check("ovr_valid_held", {31'd0, valid}, 32'd1);
        check("ovr_pulse", 32'(ovr_cnt - ovr0), 32'd1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        check("ovr_accept_valid", {31'd0, valid}, 32'd0);
        check_byte("ovr_accept", 8'h11);
        ready = 1'b1;
        drive_bit(1'b1, 5);

        // Reset during bit 4 of 0x99, held until the frame has passed.
        ferr0 = ferr_cnt;
        ovr0  = ovr_cnt;
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (5 * BIT_CYC + 4) @(posedge clk);
                #3;
                rstn = 1'b0;
                #1;
                check("mid_rst_busy", {31'd0, busy}, 32'd0);
                check("mid_rst_data", {24'd0, data}, 32'd0);
                check("mid_rst_valid", {31'd0, valid}, 32'd0);
            end
        join
        drive_bit(1'b1, 4);
        rstn = 1'b1;
        drive_bit(1'b1, 20);
        check("mid_rst_nobyte", 32'(got_q.size()), 32'd0);
        check("mid_rst_busy_after", {31'd0, busy}, 32'd0);
        send_frame(8'h42, 1'b1);
        drive_bit(1'b1, 20);
        check_byte("post_rst", 8'h42);
        check("post_rst_ferr", 32'(ferr_cnt - ferr0), 32'd0);
        check("post_rst_ovr", 32'(ovr_cnt - ovr0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
